// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - single-byte register read/write sequencer for a byte-level I2C master
// Every controller strobe is registered and lasts exactly the one cycle of its issuing state.
module i2c_reg_sequencer #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int TO_W           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_dev_addr,
   input  logic [7:0] cmd_reg_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [1:0] rsp_err,
   output logic [6:0] ctl_addr,
   output logic       ctl_r_wbar,
   output logic       ctl_send_start,
   output logic       ctl_send_stop,
   output logic       ctl_send_ack,
   output logic       ctl_send_nack,
   output logic [7:0] ctl_data_in,
   output logic       ctl_write_enable,
   output logic       ctl_read_enable,
   input  logic [7:0] ctl_data_out,
   input  logic       ctl_byte_io_complete,
   input  logic       ctl_slave_ack_received,
   input  logic       ctl_slave_nack_received,
   input  logic       ctl_communication_ongoing
);

   typedef enum logic [3:0] {
      S_IDLE, S_START_W, S_WAIT_A, S_SEND_REG, S_WAIT_R, S_SEND_DATA, S_WAIT_D, S_STOP,
      S_WAIT_STOP, S_START_R, S_WAIT_AR, S_RX, S_WAIT_RX, S_NACK, S_DONE
   } state_t;

   state_t          r_state, w_next;
   logic            r_bio_prev, r_rw, r_rd_phase;
   logic [TO_W-1:0] r_to_cnt;
   logic [7:0]      r_reg, r_wdata, r_rx_byte, r_data_in, r_rsp_rdata;
   logic [6:0]      r_addr;
   logic [1:0]      r_err, r_rsp_err;
   logic            r_cmd_ready, r_rsp_valid, r_r_wbar;
   logic            r_start, r_stop, r_ack, r_nack, r_we, r_re;
   logic            w_byte_done, w_ack, w_to, w_err_set;
   logic [1:0]      w_err_val, w_err_final;

   function automatic logic is_wait(input state_t s);
      return s inside {S_WAIT_A, S_WAIT_R, S_WAIT_D, S_WAIT_STOP, S_WAIT_AR, S_WAIT_RX};
   endfunction

   assign w_byte_done = ctl_byte_io_complete & ~r_bio_prev;
   // A byte with neither or both status flags set is treated as not acknowledged.
   assign w_ack       = ctl_slave_ack_received & ~ctl_slave_nack_received;
   assign w_to        = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign w_err_final = (r_err != 2'd0 || !w_err_set) ? r_err : w_err_val;

   always_comb begin
      w_next    = r_state;
      w_err_set = 1'b0;
      w_err_val = 2'd0;
      case (r_state)
         S_IDLE:      if (cmd_valid && r_cmd_ready) w_next = S_START_W;
         S_START_W:   w_next = S_WAIT_A;
         S_SEND_REG:  w_next = S_WAIT_R;
         S_SEND_DATA: w_next = S_WAIT_D;
         S_STOP:      w_next = S_WAIT_STOP;
         S_START_R:   w_next = S_WAIT_AR;
         S_RX:        w_next = S_WAIT_RX;
         S_NACK:      w_next = S_WAIT_STOP;
         S_WAIT_A, S_WAIT_R, S_WAIT_D, S_WAIT_AR: begin
            if (w_byte_done) begin
               if (w_ack) begin
                  case (r_state)
                     S_WAIT_A: w_next = S_SEND_REG;
                     S_WAIT_R: w_next = r_rw ? S_STOP : S_SEND_DATA;
                     S_WAIT_D: w_next = S_STOP;
                     default:  w_next = S_RX;
                  endcase
               end else begin
                  w_next    = S_STOP;
                  w_err_set = 1'b1;
                  w_err_val = (r_state == S_WAIT_A || r_state == S_WAIT_AR) ? 2'd1 : 2'd2;
               end
            end
         end
         S_WAIT_RX:   if (w_byte_done) w_next = S_NACK;
         // The first STOP of a clean read is the turnaround before the repeated start.
         S_WAIT_STOP: if (!ctl_communication_ongoing)
                         w_next = (r_rw && !r_rd_phase && r_err == 2'd0) ? S_START_R : S_DONE;
         S_DONE:      w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
      // Timeout only applies when no event moved the FSM this cycle; no STOP is attempted.
      if (is_wait(r_state) && w_next == r_state && w_to) begin
         w_next    = S_DONE;
         w_err_set = 1'b1;
         w_err_val = 2'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_bio_prev  <= 1'b0;
         r_rw        <= 1'b0;
         r_rd_phase  <= 1'b0;
         r_to_cnt    <= '0;
         r_reg       <= 8'h00;
         r_wdata     <= 8'h00;
         r_rx_byte   <= 8'h00;
         r_data_in   <= 8'h00;
         r_rsp_rdata <= 8'h00;
         r_addr      <= 7'h00;
         r_err       <= 2'd0;
         r_rsp_err   <= 2'd0;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_r_wbar    <= 1'b0;
         r_start     <= 1'b0;
         r_stop      <= 1'b0;
         r_ack       <= 1'b0;
         r_nack      <= 1'b0;
         r_we        <= 1'b0;
         r_re        <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_bio_prev  <= ctl_byte_io_complete;
         r_err       <= w_err_final;
         r_cmd_ready <= (w_next == S_IDLE);
         r_rsp_valid <= (w_next == S_DONE);
         r_start     <= (w_next == S_START_W) || (w_next == S_START_R);
         r_stop      <= (w_next == S_STOP);
         r_ack       <= (w_next == S_RX);
         r_nack      <= (w_next == S_NACK);
         r_we        <= (w_next == S_SEND_REG) || (w_next == S_SEND_DATA);
         r_re        <= (r_state == S_WAIT_RX) && w_byte_done;
         if (is_wait(w_next) && w_next != r_state)
            r_to_cnt <= '0;
         else if (is_wait(r_state))
            r_to_cnt <= r_to_cnt + 1'b1;
         if (r_state == S_IDLE && w_next == S_START_W) begin
            r_rw       <= cmd_rw;
            r_addr     <= cmd_dev_addr;
            r_reg      <= cmd_reg_addr;
            r_wdata    <= cmd_wdata;
            r_err      <= 2'd0;
            r_rd_phase <= 1'b0;
            r_r_wbar   <= 1'b0;
         end
         if (w_next == S_START_R) begin
            r_r_wbar   <= 1'b1;
            r_rd_phase <= 1'b1;
         end
         if (w_next == S_SEND_REG)  r_data_in <= r_reg;
         if (w_next == S_SEND_DATA) r_data_in <= r_wdata;
         if (r_state == S_WAIT_RX && w_byte_done) r_rx_byte <= ctl_data_out;
         if (w_next == S_DONE) begin
            r_rsp_err <= w_err_final;
            if (r_rw && w_err_final == 2'd0) r_rsp_rdata <= r_rx_byte;
         end
      end
   end

   assign cmd_ready        = r_cmd_ready;
   assign rsp_valid        = r_rsp_valid;
   assign rsp_rdata        = r_rsp_rdata;
   assign rsp_err          = r_rsp_err;
   assign ctl_addr         = r_addr;
   assign ctl_r_wbar       = r_r_wbar;
   assign ctl_send_start   = r_start;
   assign ctl_send_stop    = r_stop;
   assign ctl_send_ack     = r_ack;
   assign ctl_send_nack    = r_nack;
   assign ctl_data_in      = r_data_in;
   assign ctl_write_enable = r_we;
   assign ctl_read_enable  = r_re;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb/tb_i2c_reg_sequencer.sv - directed bench for i2c_reg_sequencer with a byte-level controller model
module tb_i2c_reg_sequencer;

   localparam int TO = 100;

   logic       clk;
   logic       reset;
   logic       cmd_valid, cmd_ready, cmd_rw;
   logic [6:0] cmd_dev_addr;
   logic [7:0] cmd_reg_addr, cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_err;
   logic [6:0] ctl_addr;
   logic       ctl_r_wbar, ctl_send_start, ctl_send_stop, ctl_send_ack, ctl_send_nack;
   logic [7:0] ctl_data_in, ctl_data_out;
   logic       ctl_write_enable, ctl_read_enable;
   logic       ctl_byte_io_complete, ctl_slave_ack_received, ctl_slave_nack_received;
   logic       ctl_communication_ongoing;

   i2c_reg_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ctl_addr(ctl_addr), .ctl_r_wbar(ctl_r_wbar),
      .ctl_send_start(ctl_send_start), .ctl_send_stop(ctl_send_stop),
      .ctl_send_ack(ctl_send_ack), .ctl_send_nack(ctl_send_nack),
      .ctl_data_in(ctl_data_in), .ctl_write_enable(ctl_write_enable),
      .ctl_read_enable(ctl_read_enable), .ctl_data_out(ctl_data_out),
      .ctl_byte_io_complete(ctl_byte_io_complete),
      .ctl_slave_ack_received(ctl_slave_ack_received),
      .ctl_slave_nack_received(ctl_slave_nack_received),
      .ctl_communication_ongoing(ctl_communication_ongoing)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controller model configuration, written only by the stimulus.
   int         m_nack_idx = -1;
   bit         m_hang     = 1'b0;
   bit         m_hang_rx  = 1'b0;
   logic [7:0] m_rdata    = 8'h00;

   // Controller model state and logs, written only by the model.
   int         m_cnt = 0, m_op = 0, m_byte_idx = 0, m_cyc = 0, m_start_cyc = 0, m_rsp_cyc = 0;
   int         n_start = 0, n_stop = 0, n_sack = 0, n_snack = 0, n_we = 0, n_re = 0;
   logic [7:0] we_data [64];
   logic       start_rw [64];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic begin_op(input int op, input bit hold);
      m_op = op;
      m_cnt = hold ? 0 : 3;
      ctl_slave_ack_received  = 1'b0;
      ctl_slave_nack_received = 1'b0;
   endtask

   // Inputs change on the falling edge; the DUT samples them on the rising edge.
   always @(negedge clk) begin
      m_cyc++;
      ctl_byte_io_complete = 1'b0;
      if (!reset) begin
         m_cnt = 0;
         m_op = 0;
         m_byte_idx = 0;
         ctl_communication_ongoing = 1'b0;
         ctl_slave_ack_received = 1'b0;
         ctl_slave_nack_received = 1'b0;
         ctl_data_out = 8'h00;
      end else begin
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               case (m_op)
                  1: begin
                     ctl_byte_io_complete = 1'b1;
                     ctl_slave_ack_received  = (m_byte_idx != m_nack_idx);
                     ctl_slave_nack_received = (m_byte_idx == m_nack_idx);
                     m_byte_idx++;
                  end
                  2: begin
                     ctl_byte_io_complete = 1'b1;
                     ctl_data_out = m_rdata;
                  end
                  3: ctl_communication_ongoing = 1'b0;
                  default: ;
               endcase
            end
         end
         if (ctl_send_start) begin
            start_rw[n_start & 63] = ctl_r_wbar;
            n_start++;
            m_start_cyc = m_cyc;
            ctl_communication_ongoing = 1'b1;
            begin_op(1, m_hang);
         end
         if (ctl_write_enable) begin
            we_data[n_we & 63] = ctl_data_in;
            n_we++;
            begin_op(1, m_hang);
         end
         if (ctl_send_ack) begin
            n_sack++;
            begin_op(2, m_hang_rx);
         end
         if (ctl_send_nack) begin
            n_snack++;
            begin_op(3, 1'b0);
         end
         if (ctl_send_stop) begin
            n_stop++;
            begin_op(3, 1'b0);
         end
         if (ctl_read_enable) n_re++;
         if (rsp_valid) begin
            m_rsp_cyc = m_cyc;
            m_byte_idx = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, output logic [1:0] err, output logic [7:0] rdata);
      bit got;
      cmd_rw = rw;
      cmd_dev_addr = dev;
      cmd_reg_addr = rg;
      cmd_wdata = wd;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("busy_after_accept", cmd_ready, 1'b0);
      check("ctl_addr", ctl_addr, dev);
      got = 1'b0;
      err = 2'bxx;
      rdata = 8'hxx;
      for (int i = 0; i < 1000 && !got; i++) begin
         if (rsp_valid) begin
            got = 1'b1;
            err = rsp_err;
            rdata = rsp_rdata;
         end else begin
            @(negedge clk);
         end
      end
      check("rsp_seen", got, 1'b1);
      @(negedge clk);
      check("ready_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
   endtask

   int s_start, s_stop, s_sack, s_snack, s_we, s_re;
   task automatic snap();
      s_start = n_start; s_stop = n_stop; s_sack = n_sack;
      s_snack = n_snack; s_we = n_we; s_re = n_re;
   endtask

   initial begin
      logic [1:0] err;
      logic [7:0] rd;
      bit         seen;
      reset = 1'b0;
      cmd_valid = 1'b0;
      cmd_rw = 1'b0;
      cmd_dev_addr = 7'h00;
      cmd_reg_addr = 8'h00;
      cmd_wdata = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_status", {cmd_ready, rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 2'd0, 8'h00});
      check("reset_ctl", {ctl_addr, ctl_r_wbar, ctl_data_in}, 16'h0000);
      check("reset_strobes", {ctl_send_start, ctl_send_stop, ctl_send_ack, ctl_send_nack,
                              ctl_write_enable, ctl_read_enable}, 6'b0);
      reset = 1'b1;
      @(negedge clk);

      // Register write, all bytes acknowledged
      snap();
      run_cmd(1'b0, 7'h50, 8'h10, 8'hA5, err, rd);
      check("wr_err", err, 2'd0);
      check("wr_starts", n_start - s_start, 1);
      check("wr_we_count", n_we - s_we, 2);
      check("wr_byte0", we_data[s_we & 63], 8'h10);
      check("wr_byte1", we_data[(s_we + 1) & 63], 8'hA5);
      check("wr_stops", n_stop - s_stop, 1);
      check("wr_rdata_hold", rd, 8'h00);

      // Register read with repeated start
      m_rdata = 8'h3C;
      snap();
      run_cmd(1'b1, 7'h50, 8'h20, 8'h00, err, rd);
      check("rd_err", err, 2'd0);
      check("rd_rdata", rd, 8'h3C);
      check("rd_starts", n_start - s_start, 2);
      check("rd_start_rw", {start_rw[s_start & 63], start_rw[(s_start + 1) & 63]}, 2'b01);
      check("rd_reg_byte", {n_we - s_we, 24'(we_data[s_we & 63])}, {8'd1, 24'h20});
      check("rd_stops", n_stop - s_stop, 1);
      check("rd_ack_re_nack", {n_sack - s_sack, n_re - s_re, n_snack - s_snack}, {32'd1, 32'd1, 32'd1});

      // Address NACK on write
      m_nack_idx = 0;
      snap();
      run_cmd(1'b0, 7'h21, 8'h01, 8'h02, err, rd);
      check("anack_err", err, 2'd1);
      check("anack_no_we", n_we - s_we, 0);
      check("anack_stops", n_stop - s_stop, 1);
      check("anack_rdata_hold", rd, 8'h3C);

      // Data byte NACK on write
      m_nack_idx = 2;
      snap();
      run_cmd(1'b0, 7'h50, 8'h11, 8'h5A, err, rd);
      check("dnack_err", err, 2'd2);
      check("dnack_we", n_we - s_we, 2);
      check("dnack_stops", n_stop - s_stop, 1);

      // Register NACK during read: no repeated start
      m_nack_idx = 1;
      snap();
      run_cmd(1'b1, 7'h50, 8'h22, 8'h00, err, rd);
      check("rnack_err", err, 2'd2);
      check("rnack_starts", n_start - s_start, 1);
      check("rnack_stops", n_stop - s_stop, 1);
      check("rnack_no_rx", n_sack - s_sack, 0);
      check("rnack_rdata_hold", rd, 8'h3C);

      // Controller never completes the address byte
      m_nack_idx = -1;
      m_hang = 1'b1;
      snap();
      run_cmd(1'b0, 7'h50, 8'h10, 8'hA5, err, rd);
      check("to_err", err, 2'd3);
      check("to_no_stop", n_stop - s_stop, 0);
      check("to_latency", m_rsp_cyc - m_start_cyc, TO + 1);
      m_hang = 1'b0;

      // Reset while waiting for the read byte
      m_hang_rx = 1'b1;
      snap();
      cmd_rw = 1'b1;
      cmd_dev_addr = 7'h50;
      cmd_reg_addr = 8'h20;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (n_sack != s_sack) seen = 1'b1;
         else @(negedge clk);
      end
      check("rst_reached_rx", seen, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_status", {cmd_ready, rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 2'd0, 8'h00});
      check("midrst_ctl", {ctl_addr, ctl_r_wbar, ctl_data_in}, 16'h0000);
      check("midrst_strobes", {ctl_send_start, ctl_send_stop, ctl_send_ack, ctl_send_nack,
                               ctl_write_enable, ctl_read_enable}, 6'b0);
      reset = 1'b1;
      m_hang_rx = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_no_extra_stop", n_stop - s_stop, 1);
      snap();
      run_cmd(1'b0, 7'h50, 8'h33, 8'hC3, err, rd);
      check("post_rst_err", err, 2'd0);
      check("post_rst_we", {n_we - s_we, 24'(we_data[(s_we + 1) & 63])}, {8'd2, 24'hC3});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the cycle budget");
      $fatal(1, "watchdog expired");
   end

endmodule
